// File: rtl/avalon_ram_ws.sv
// Avalon-MM word RAM slave with programmable wait states, backdoor preload,
// a sticky access-error flag and a saturating completed-transfer counter.
module avalon_ram_ws #(
    parameter int          WORDS       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_STATES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               address,
    input  logic                      read,
    input  logic                      write,
    input  logic [31:0]               writedata,
    input  logic [3:0]                byteenable,
    output logic                      waitrequest,
    output logic [31:0]               readdata,
    input  logic                      load_en,
    input  logic [$clog2(WORDS)-1:0]  load_addr,
    input  logic [31:0]               load_data,
    output logic                      err,
    output logic [15:0]               access_count
);

    // state | meaning
    // IDLE  | no transfer in progress, waiting for read or write
    // WAIT  | counting down the remaining wait states
    // ACK   | transfer performed on entry, waitrequest released
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam int          AW       = $clog2(WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [32:0] SPAN     = 33'(4 * WORDS);

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [31:0]   mem [WORDS];
    logic [32:0]   offset;
    logic [AW-1:0] index;
    logic          req, both, in_range, xfer;

    assign req         = read | write;
    assign both        = read & write;
    // 33-bit subtraction: addresses below BASE_ADDR wrap to huge offsets and fail the span test
    assign offset      = {1'b0, address} - {1'b0, BASE_ADDR};
    assign in_range    = (offset < SPAN) && (address[1:0] == 2'b00);
    assign index       = offset[AW+1:2];
    assign waitrequest = req && (state != ACK);
    assign xfer        = (state != ACK) && (state_nxt == ACK);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            readdata     <= 32'd0;
            err          <= 1'b0;
            access_count <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (xfer) begin
                if (access_count != 16'hFFFF) begin
                    access_count <= access_count + 16'd1;
                end
                if (both || !in_range) begin
                    err <= 1'b1;
                end
                if (both) begin
                    readdata <= 32'hFFFFFFFF;
                end else if (read) begin
                    readdata <= in_range ? mem[index] : 32'd0;
                end
            end
        end
    end

    // Array is never reset; preload stays live during reset and wins over a same-edge bus write.
    always_ff @(posedge clk) begin
        if (reset && xfer && write && !read && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    mem[index][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule
